// File: rtl/ce_rate_gen.sv
`default_nettype none
// ============================================================================
// Module      : ce_rate_gen
// Description : Clock-enable generator for the PET2001 core, all logic on the
//               single 112 MHz system clock.
//               - Video side: free-running (VID_LOG2+1)-bit counter decoded
//                 into a double-pixel-rate enable and two anti-phase
//                 pixel-rate enables.
//               - CPU side: reloadable divider whose reload value comes from
//                 a speed selector or a tape-turbo override. A new reload
//                 value is adopted only at the end of a CPU period, so the
//                 CPU never sees a truncated or stretched period.
//               - A stall input masks the CPU enable without disturbing the
//                 slot grid.
// Option      : `define CE_RATE_GEN_CATCHUP_EN to remember one slot lost to
//               stall and replay it on the first unstalled clock.
//
// Ports
//   clk          in   1  system clock (posedge)
//   reset        in   1  asynchronous, active-high
//   i_rate_sel   in   2  CPU speed select: 0=x1, 1=x2, 2=x4, 3=x8
//   i_turbo      in   1  force reload value TURBO_DIV (overrides rate_sel)
//   i_stall      in   1  suppress o_ce_cpu while high
//   o_ce_vid2    out  1  double-pixel-rate enable
//   o_ce_vid1p   out  1  pixel-rate enable, phase 0
//   o_ce_vid1n   out  1  pixel-rate enable, phase 180 degrees
//   o_ce_cpu     out  1  CPU clock enable
//   o_rate_ack   out  1  one-cycle pulse when a changed reload value loads
//
// Revision    : 1.0  initial release
// ============================================================================
module ce_rate_gen #(
    parameter int VID_LOG2  = 3,
    parameter int CPU_DIV_W = 7,
    parameter int CPU_BASE  = 111,
    parameter int TURBO_DIV = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_rate_sel,
    input  logic       i_turbo,
    input  logic       i_stall,
    output logic       o_ce_vid2,
    output logic       o_ce_vid1p,
    output logic       o_ce_vid1n,
    output logic       o_ce_cpu,
    output logic       o_rate_ack
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Video counter value at which the 180-degree pixel enable is decoded.
    localparam logic [VID_LOG2:0] c_VID_HALF = {1'b1, {VID_LOG2{1'b0}}};

    localparam logic [CPU_DIV_W-1:0] c_ONE      = CPU_DIV_W'(1);
    // Reload value seen out of reset; the first period is CPU_BASE+1 clocks.
    localparam logic [CPU_DIV_W-1:0] c_CUR_RST  = CPU_DIV_W'(CPU_BASE);
    localparam logic [CPU_DIV_W-1:0] c_TURBO    = CPU_DIV_W'(TURBO_DIV);
    // Base period length, formed at counter width before any shifting so
    // that the rate table wraps the same way the counter does.
    localparam logic [CPU_DIV_W-1:0] c_BASE_P1  = CPU_DIV_W'(CPU_BASE + 1);

    // Reload table: period halves with every step of rate_sel.
    localparam logic [CPU_DIV_W-1:0] c_RELOAD_X1 = (c_BASE_P1 >> 0) - c_ONE;
    localparam logic [CPU_DIV_W-1:0] c_RELOAD_X2 = (c_BASE_P1 >> 1) - c_ONE;
    localparam logic [CPU_DIV_W-1:0] c_RELOAD_X4 = (c_BASE_P1 >> 2) - c_ONE;
    localparam logic [CPU_DIV_W-1:0] c_RELOAD_X8 = (c_BASE_P1 >> 3) - c_ONE;

    // ------------------------------------------------------------------------
    // Video divider
    // ------------------------------------------------------------------------
    logic [VID_LOG2:0] r_vdiv;
    logic              r_ce_vid2;
    logic              r_ce_vid1p;
    logic              r_ce_vid1n;

    logic              w_vid2_hit;
    logic              w_vid1p_hit;
    logic              w_vid1n_hit;

    assign w_vid2_hit  = (r_vdiv[VID_LOG2-1:0] == '0);
    assign w_vid1p_hit = (r_vdiv == '0);
    assign w_vid1n_hit = (r_vdiv == c_VID_HALF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vdiv     <= '0;
            r_ce_vid2  <= 1'b0;
            r_ce_vid1p <= 1'b0;
            r_ce_vid1n <= 1'b0;
        end else begin
            // Power-of-two period: the counter simply wraps.
            r_vdiv     <= r_vdiv + 1'b1;
            r_ce_vid2  <= w_vid2_hit;
            r_ce_vid1p <= w_vid1p_hit;
            r_ce_vid1n <= w_vid1n_hit;
        end
    end

    // ------------------------------------------------------------------------
    // CPU divider
    // ------------------------------------------------------------------------
    logic [CPU_DIV_W-1:0] r_cdiv;
    logic [CPU_DIV_W-1:0] r_cur;
    logic                 r_ce_cpu;
    logic                 r_rate_ack;

    logic [CPU_DIV_W-1:0] w_rate_reload;
    logic [CPU_DIV_W-1:0] w_nxt;
    logic                 w_boundary;
    logic                 w_slot;

    always_comb begin
        w_rate_reload = c_RELOAD_X1;
        case (i_rate_sel)
            2'd0:    w_rate_reload = c_RELOAD_X1;
            2'd1:    w_rate_reload = c_RELOAD_X2;
            2'd2:    w_rate_reload = c_RELOAD_X4;
            default: w_rate_reload = c_RELOAD_X8;
        endcase
    end

    // Requested reload value; only looked at on the boundary clock, so
    // selector changes mid-period are harmless.
    assign w_nxt      = i_turbo ? c_TURBO : w_rate_reload;

    // Last clock of the current period. With r_cur==0 the boundary and the
    // slot coincide, giving a slot every clock.
    assign w_boundary = (r_cdiv == r_cur);
    assign w_slot     = (r_cdiv == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cdiv     <= '0;
            r_cur      <= c_CUR_RST;
            r_rate_ack <= 1'b0;
        end else if (w_boundary) begin
            r_cdiv     <= '0;
            r_cur      <= w_nxt;
            // Acknowledge only an actual change of period length.
            r_rate_ack <= (w_nxt != r_cur);
        end else begin
            r_cdiv     <= r_cdiv + c_ONE;
            r_rate_ack <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // CPU enable and stall handling
    // ------------------------------------------------------------------------
`ifdef CE_RATE_GEN_CATCHUP_EN
    // One slot of memory: a slot swallowed by stall is replayed on the first
    // unstalled clock. Further slots lost while already pending are dropped.
    logic r_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_ce_cpu  <= 1'b0;
        end else if (i_stall) begin
            r_ce_cpu <= 1'b0;
            if (w_slot) begin
                r_pending <= 1'b1;
            end
        end else if (w_slot) begin
            // A fresh slot takes priority; any pending replay waits one more
            // clock, so the two enables come out back to back.
            r_ce_cpu <= 1'b1;
        end else if (r_pending) begin
            r_ce_cpu  <= 1'b1;
            r_pending <= 1'b0;
        end else begin
            r_ce_cpu <= 1'b0;
        end
    end
`else
    // Slots that land while stalled are simply lost; the grid never moves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ce_cpu <= 1'b0;
        end else begin
            r_ce_cpu <= w_slot & ~i_stall;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_ce_vid2  = r_ce_vid2;
    assign o_ce_vid1p = r_ce_vid1p;
    assign o_ce_vid1n = r_ce_vid1n;
    assign o_ce_cpu   = r_ce_cpu;
    assign o_rate_ack = r_rate_ack;

endmodule
`default_nettype wire

// File: tb/tb_ce_rate_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ce_rate_gen
// Description : Self-checking bench for ce_rate_gen. A reference model built
//               on absolute clock indices and period lengths predicts every
//               output each clock; predictions are queued and a separate
//               monitor compares them against the DUT after each posedge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ce_rate_gen;

    localparam int VID_LOG2  = 3;
    localparam int CPU_DIV_W = 7;
    localparam int CPU_BASE  = 111;
    localparam int TURBO_DIV = 5;
    localparam int MODV      = 1 << CPU_DIV_W;
    localparam int VP        = 1 << VID_LOG2;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [1:0] rate_sel = 2'd0;
    logic       turbo    = 1'b0;
    logic       stall    = 1'b0;
    logic       ce_vid2;
    logic       ce_vid1p;
    logic       ce_vid1n;
    logic       ce_cpu;
    logic       rate_ack;

    always #5 clk = ~clk;

    ce_rate_gen #(
        .VID_LOG2  (VID_LOG2),
        .CPU_DIV_W (CPU_DIV_W),
        .CPU_BASE  (CPU_BASE),
        .TURBO_DIV (TURBO_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_rate_sel (rate_sel),
        .i_turbo    (turbo),
        .i_stall    (stall),
        .o_ce_vid2  (ce_vid2),
        .o_ce_vid1p (ce_vid1p),
        .o_ce_vid1n (ce_vid1n),
        .o_ce_cpu   (ce_cpu),
        .o_rate_ack (rate_ack)
    );

    typedef struct packed {
        logic vid2;
        logic vid1p;
        logic vid1n;
        logic cpu;
        logic ack;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model state: clocks since reset release, start clock of the
    // current CPU period, its length, and the remembered stalled slot.
    int   m_k;
    int   m_last_slot;
    int   m_period;
    bit   m_pending;

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    endtask

    function automatic int model_period(input logic [1:0] rs, input logic tb);
        int base;
        if (tb) return (TURBO_DIV % MODV) + 1;
        base = (CPU_BASE + 1) % MODV;
        return (((base >> rs) - 1 + MODV) % MODV) + 1;
    endfunction

    task automatic model_reset();
        m_k         = 0;
        m_last_slot = 0;
        m_period    = (CPU_BASE % MODV) + 1;
        m_pending   = 1'b0;
    endtask

    // Apply inputs for one clock and queue the outputs expected after it.
    task automatic cyc(input logic [1:0] rs, input logic tb, input logic st,
                       input logic rst_in);
        exp_t e;
        bit   slot;
        int   newp;
        @(negedge clk);
        rate_sel = rs;
        turbo    = tb;
        stall    = st;
        if (rst_in && !reset) begin
            reset = 1'b1;
            #1;
            chk("async_rst_vid2",  ce_vid2,  1'b0);
            chk("async_rst_vid1p", ce_vid1p, 1'b0);
            chk("async_rst_vid1n", ce_vid1n, 1'b0);
            chk("async_rst_cpu",   ce_cpu,   1'b0);
            chk("async_rst_ack",   rate_ack, 1'b0);
        end else begin
            reset = rst_in;
        end
        e = '0;
        if (reset) begin
            model_reset();
        end else begin
            e.vid2  = ((m_k % VP) == 0);
            e.vid1p = ((m_k % (2 * VP)) == 0);
            e.vid1n = ((m_k % (2 * VP)) == VP);
            slot    = (m_k == m_last_slot);
`ifdef CE_RATE_GEN_CATCHUP_EN
            if (st) begin
                e.cpu = 1'b0;
                if (slot) m_pending = 1'b1;
            end else if (slot) begin
                e.cpu = 1'b1;
            end else if (m_pending) begin
                e.cpu     = 1'b1;
                m_pending = 1'b0;
            end
`else
            e.cpu = slot && !st;
`endif
            if (m_k == m_last_slot + m_period - 1) begin
                newp        = model_period(rs, tb);
                e.ack       = (newp != m_period);
                m_period    = newp;
                m_last_slot = m_k + 1;
            end
            m_k++;
        end
        sb.push_back(e);
    endtask

    // Monitor: compare every queued prediction one step after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ce_vid2",  ce_vid2,  e.vid2);
                chk("ce_vid1p", ce_vid1p, e.vid1p);
                chk("ce_vid1n", ce_vid1n, e.vid1n);
                chk("ce_cpu",   ce_cpu,   e.cpu);
                chk("rate_ack", rate_ack, e.ack);
            end
        end
    end

    initial begin : driver
        model_reset();
        // Reset held, then released with defaults.
        for (int i = 0; i < 3; i++) cyc(2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) cyc(2'd0, 1'b0, 1'b0, 1'b0);

        // x8 requested mid-period; then re-requesting x8 must not ack.
        for (int i = 0; i < 150; i++) cyc(2'd3, 1'b0, 1'b0, 1'b0);

        // Turbo over x4, then back to x4.
        for (int i = 0; i < 60; i++) cyc(2'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 90; i++) cyc(2'd2, 1'b0, 1'b0, 1'b0);

        // Stall across three x8 slots, then release.
        for (int i = 0; i < 30; i++) cyc(2'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 45; i++) cyc(2'd3, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) cyc(2'd3, 1'b0, 1'b0, 1'b0);

`ifdef CE_RATE_GEN_CATCHUP_EN
        // Stall until a slot is about to occur with a replay pending, then
        // drop stall exactly on that slot clock.
        for (int i = 0; i < 60 && !(m_pending && m_k == m_last_slot); i++)
            cyc(2'd3, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(2'd3, 1'b0, 1'b0, 1'b0);
`endif

        // Reset mid-period at x2, then release.
        for (int i = 0; i < 70; i++) cyc(2'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(2'd1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) cyc(2'd1, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        begin
            logic [1:0] rs;
            logic       tb;
            logic       rr;
            rs = 2'd0;
            tb = 1'b0;
            for (int i = 0; i < 2500; i++) begin
                if ($urandom_range(0, 39) == 0) rs = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 59) == 0) tb = ~tb;
                rr = ($urandom_range(0, 799) == 0);
                cyc(rs, tb, 1'($urandom_range(0, 3) == 0), rr);
            end
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 1'(sb.size() == 0), 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
